// File: rtl/spi_ram.sv
// spi_ram: single-port 8-bit RAM addressed and accessed by 10-bit SPI slave command words.
// Optional macro RAM_ADDR_AUTOINC_EN post-increments wr_addr/rd_addr after each data access.
`timescale 1ns/1ps
module spi_ram #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] din,
    input  logic       rx_valid,
    output logic [7:0] dout,
    output logic       tx_valid
);

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;
    localparam int         MEM_AW      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    logic [ADDR_SIZE-1:0] r_wr_addr;
    logic [ADDR_SIZE-1:0] r_rd_addr;
    logic [7:0]           r_mem [0:MEM_DEPTH-1];
    logic [7:0]           r_dout;
    logic                 r_tx_valid;

    logic                 w_wrInRange;
    logic                 w_rdInRange;
    logic                 w_wrEn;
    logic [MEM_AW-1:0]    w_wrIdx;
    logic [MEM_AW-1:0]    w_rdIdx;

    assign w_wrInRange = (32'(r_wr_addr) < MEM_DEPTH);
    assign w_rdInRange = (32'(r_rd_addr) < MEM_DEPTH);
    assign w_wrIdx     = r_wr_addr[MEM_AW-1:0];
    assign w_rdIdx     = r_rd_addr[MEM_AW-1:0];
    assign w_wrEn      = rst_n && rx_valid && (din[9:8] == CMD_WR_DATA) && w_wrInRange;

    assign dout     = r_dout;
    assign tx_valid = r_tx_valid;

`ifdef RAM_ADDR_AUTOINC_EN
    // Wrap at the last real location; out-of-range addresses just roll over mod 256.
    function automatic logic [ADDR_SIZE-1:0] nextAddr(input logic [ADDR_SIZE-1:0] a);
        return (32'(a) == MEM_DEPTH - 1) ? '0 : a + ADDR_SIZE'(1);
    endfunction
`endif

    // Storage has no reset so contents survive rst_n; writes are gated off while in reset.
    always_ff @(posedge clk) begin
        if (w_wrEn) begin
            r_mem[w_wrIdx] <= din[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_addr  <= '0;
            r_rd_addr  <= '0;
            r_dout     <= 8'h00;
            r_tx_valid <= 1'b0;
        end else if (rx_valid) begin
            case (din[9:8])
                CMD_WR_ADDR: begin
                    r_wr_addr  <= din[7:0];
                    r_tx_valid <= 1'b0;
                end
                CMD_WR_DATA: begin
                    r_tx_valid <= 1'b0;
`ifdef RAM_ADDR_AUTOINC_EN
                    r_wr_addr  <= nextAddr(r_wr_addr);
`endif
                end
                CMD_RD_ADDR: begin
                    r_rd_addr  <= din[7:0];
                    r_tx_valid <= 1'b0;
                end
                default: begin
                    r_dout     <= w_rdInRange ? r_mem[w_rdIdx] : 8'h00;
                    r_tx_valid <= 1'b1;
`ifdef RAM_ADDR_AUTOINC_EN
                    r_rd_addr  <= nextAddr(r_rd_addr);
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_ram.sv
// Self-checking bench for spi_ram: a 256-deep and a 128-deep instance share the command stream.
`timescale 1ns/1ps
module tb_spi_ram;

    logic       clk;
    logic       rst_n;
    logic [9:0] din;
    logic       rx_valid;
    logic [7:0] doutA, doutB;
    logic       txA, txB;

    int tests  = 0;
    int failed = 0;

    // Reference model state: memories, addresses and expected read queues per instance.
    logic [7:0] mA [256];
    logic [7:0] mB [256];
    logic [7:0] wA, rA, wB, rB;
    logic [7:0] qA [$];
    logic [7:0] qB [$];
    logic [7:0] eA, eB;

    spi_ram #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dutA (
        .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid),
        .dout(doutA), .tx_valid(txA)
    );

    spi_ram #(.MEM_DEPTH(128), .ADDR_SIZE(8)) dutB (
        .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid),
        .dout(doutB), .tx_valid(txB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic modelReset();
        wA = 8'h00; rA = 8'h00; wB = 8'h00; rB = 8'h00;
    endtask

    task automatic modelApply(input logic [9:0] d);
        case (d[9:8])
            2'b00: begin wA = d[7:0]; wB = d[7:0]; end
            2'b01: begin
                mA[wA] = d[7:0];
                if (wB < 8'd128) mB[wB] = d[7:0];
`ifdef RAM_ADDR_AUTOINC_EN
                wA = wA + 8'd1;
                wB = (wB == 8'd127) ? 8'd0 : wB + 8'd1;
`endif
            end
            2'b10: begin rA = d[7:0]; rB = d[7:0]; end
            default: begin
                qA.push_back(mA[rA]);
                qB.push_back((rB < 8'd128) ? mB[rB] : 8'h00);
`ifdef RAM_ADDR_AUTOINC_EN
                rA = rA + 8'd1;
                rB = (rB == 8'd127) ? 8'd0 : rB + 8'd1;
`endif
            end
        endcase
    endtask

    task automatic send(input logic [1:0] cmd, input logic [7:0] data);
        @(negedge clk);
        din      = {cmd, data};
        rx_valid = 1'b1;
        modelApply({cmd, data});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_valid = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; din = '0; rx_valid = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (doutA !== 8'h00 || txA !== 1'b0 || doutB !== 8'h00 || txB !== 1'b0) begin
            failed++;
            $display("[TB] FAIL reset_state: A=%h/%b B=%h/%b expected 00/0", doutA, txA, doutB, txB);
        end
        @(negedge clk); rst_n = 1'b1;
        send(2'b00, 8'h00); send(2'b01, 8'h5A); send(2'b10, 8'h00); send(2'b11, 8'h00);
        eA = qA.pop_front(); eB = qB.pop_front();
        tests++;
        if (doutA !== 8'h5A || doutA !== eA || txA !== 1'b1 || doutB !== eB || txB !== 1'b1) begin
            failed++;
            $display("[TB] FAIL reset_preload: A=%h/%b B=%h/%b expected 5a/1", doutA, txA, doutB, txB);
        end
        // Assert reset mid-cycle; outputs must clear before the next clock edge.
        @(negedge clk); rx_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (doutA !== 8'h00 || txA !== 1'b0 || doutB !== 8'h00 || txB !== 1'b0) begin
            failed++;
            $display("[TB] FAIL async_reset: A=%h/%b B=%h/%b expected 00/0", doutA, txA, doutB, txB);
        end
        modelReset();
        #1 rst_n = 1'b1;
        send(2'b10, 8'h00); send(2'b11, 8'h00);
        eA = qA.pop_front(); eB = qB.pop_front();
        tests++;
        if (txA !== 1'b1 || doutA !== 8'h5A || doutA !== eA || txB !== 1'b1 || doutB !== eB) begin
            failed++;
            $display("[TB] FAIL reset_release_read: A=%h/%b B=%h/%b expected 5a/1", doutA, txA, doutB, txB);
        end
    endtask

    task automatic test_write_read();
        send(2'b00, 8'h05); send(2'b01, 8'hA5); send(2'b10, 8'h05); send(2'b11, 8'h00);
        eA = qA.pop_front(); eB = qB.pop_front();
        tests++;
        if (doutA !== 8'hA5 || doutA !== eA || txA !== 1'b1 || doutB !== eB || txB !== 1'b1) begin
            failed++;
            $display("[TB] FAIL write_read: A=%h/%b B=%h/%b expected a5/1", doutA, txA, doutB, txB);
        end
        for (int i = 0; i < 3; i++) begin
            idle(1);
            tests++;
            if (txA !== 1'b1 || doutA !== 8'hA5) begin
                failed++;
                $display("[TB] FAIL tx_level_hold: cycle %0d A=%h/%b expected a5/1", i, doutA, txA);
            end
        end
        send(2'b00, 8'h06);
        tests++;
        if (txA !== 1'b0 || doutA !== 8'hA5 || txB !== 1'b0) begin
            failed++;
            $display("[TB] FAIL tx_clear_on_wr_addr: A=%h/%b B tx=%b expected a5/0", doutA, txA, txB);
        end
    endtask

    task automatic test_addr_indep();
        send(2'b00, 8'h20); send(2'b01, 8'hC4);
        send(2'b00, 8'h10); send(2'b10, 8'h20); send(2'b01, 8'h3C); send(2'b11, 8'h00);
        eA = qA.pop_front(); eB = qB.pop_front();
        tests++;
        if (doutA !== 8'hC4 || doutA !== eA || doutB !== eB || txA !== 1'b1) begin
            failed++;
            $display("[TB] FAIL addr_indep_rd: A=%h/%b B=%h expected c4/1", doutA, txA, doutB);
        end
        send(2'b10, 8'h10); send(2'b11, 8'h00);
        eA = qA.pop_front(); eB = qB.pop_front();
        tests++;
        if (doutA !== 8'h3C || doutA !== eA || doutB !== 8'h3C || doutB !== eB) begin
            failed++;
            $display("[TB] FAIL addr_indep_wr: A=%h B=%h expected 3c", doutA, doutB);
        end
    endtask

    task automatic test_out_of_range();
        send(2'b00, 8'h10); send(2'b01, 8'h66);
        send(2'b00, 8'h90); send(2'b01, 8'hFF); send(2'b10, 8'h90); send(2'b11, 8'h00);
        eA = qA.pop_front(); eB = qB.pop_front();
        tests++;
        if (doutB !== 8'h00 || doutB !== eB || txB !== 1'b1 || doutA !== 8'hFF || doutA !== eA) begin
            failed++;
            $display("[TB] FAIL oor_read: B=%h/%b expected 00/1, A=%h expected ff", doutB, txB, doutA);
        end
        send(2'b10, 8'h10); send(2'b11, 8'h00);
        eA = qA.pop_front(); eB = qB.pop_front();
        tests++;
        if (doutB !== 8'h66 || doutB !== eB || doutA !== eA) begin
            failed++;
            $display("[TB] FAIL oor_no_alias: B=%h expected 66, A=%h expected %h", doutB, doutA, eA);
        end
    endtask

    task automatic test_autoinc();
        logic [7:0] firstA;
        send(2'b00, 8'hFF); send(2'b01, 8'h11); send(2'b01, 8'h22);
        send(2'b10, 8'hFF); send(2'b11, 8'h00);
`ifdef RAM_ADDR_AUTOINC_EN
        firstA = 8'h11;
`else
        firstA = 8'h22;
`endif
        eA = qA.pop_front(); eB = qB.pop_front();
        tests++;
        if (doutA !== firstA || doutA !== eA || doutB !== eB || txB !== 1'b1) begin
            failed++;
            $display("[TB] FAIL burst_rd0: A=%h B=%h expected %h/%h", doutA, doutB, firstA, eB);
        end
        send(2'b11, 8'h00);
        eA = qA.pop_front(); eB = qB.pop_front();
        tests++;
        if (doutA !== 8'h22 || doutA !== eA || doutB !== eB || txA !== 1'b1) begin
            failed++;
            $display("[TB] FAIL burst_rd1: A=%h B=%h expected 22/%h", doutA, doutB, eB);
        end
    endtask

    task automatic test_back_to_back();
        send(2'b00, 8'h40); send(2'b01, 8'h77); send(2'b00, 8'h50);
        for (int i = 0; i < 4; i++) send(2'b01, 8'h80 + 8'(i));
        // Pulse reset with the stream still active; the held WR_DATA lands at address 0 afterwards.
        @(negedge clk);
        din = {2'b01, 8'hD1};
        rx_valid = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        tests++;
        if (txA !== 1'b0 || doutA !== 8'h00 || txB !== 1'b0) begin
            failed++;
            $display("[TB] FAIL stream_reset_outputs: A=%h/%b B tx=%b expected 00/0", doutA, txA, txB);
        end
        #2 rst_n = 1'b1;
        modelReset();
        modelApply({2'b01, 8'hD1});
        @(posedge clk);
        #1;
        send(2'b11, 8'h00);
        eA = qA.pop_front(); eB = qB.pop_front();
        tests++;
        if (doutA !== 8'hD1 || doutA !== eA || doutB !== 8'hD1 || doutB !== eB) begin
            failed++;
            $display("[TB] FAIL stream_reset_addr0: A=%h B=%h expected d1", doutA, doutB);
        end
        send(2'b10, 8'h40); send(2'b11, 8'h00);
        eA = qA.pop_front(); eB = qB.pop_front();
        tests++;
        if (doutA !== 8'h77 || doutA !== eA || doutB !== 8'h77 || doutB !== eB) begin
            failed++;
            $display("[TB] FAIL stream_mem_survives: A=%h B=%h expected 77", doutA, doutB);
        end
        send(2'b10, 8'h50); send(2'b11, 8'h00);
        eA = qA.pop_front(); eB = qB.pop_front();
        tests++;
        if (doutA !== eA || doutB !== eB) begin
            failed++;
            $display("[TB] FAIL stream_data: A=%h B=%h expected %h/%h", doutA, doutB, eA, eB);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_addr_indep();
        test_out_of_range();
        test_autoinc();
        test_back_to_back();
        idle(2);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
